// File: rtl/spi_nand_slave_frontend_if.sv
// SPI NAND pin bundle between a host (master) and the device front end (slave).
// Signals:
//   sck    SPI clock, mode 0, driven by the host
//   cs_n   chip select, active low, driven by the host
//   si     serial data into the device, MSB first
//   so     serial data out of the device
//   so_oe  output enable for so
interface spi_nand_slave_frontend_if;
    logic sck;
    logic cs_n;
    logic si;
    logic so;
    logic so_oe;

    modport master (output sck, cs_n, si, input so, so_oe);
    modport slave  (input sck, cs_n, si, output so, so_oe);
endinterface

// File: rtl/spi_nand_slave_frontend.sv
// SPI NAND device-side front end. Oversamples the SPI pins on clk, decodes
// single-bit mode-0 command frames, holds the feature registers and WEL, and
// streams cache data, feature bytes or ID bytes on so.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   spi             SPI pins (sck, cs_n, si in; so, so_oe out)
//   oip             operation-in-progress from the array controller
//   cache_rd_*      cache read strobe/column out, data back one clk later
//   feat_a0/b0      block-lock and configuration registers
//   wel             write-enable latch
//   reset_req       one-clk pulse on a completed 0xFF frame
//   unsup_cmd       one-clk pulse when an undefined opcode is decoded
module spi_nand_slave_frontend #(
    parameter logic [7:0] ID_MFR   = 8'h2C,
    parameter logic [7:0] ID_DEV   = 8'h14,
    parameter int         CACHE_AW = 12
) (
    input  logic                clk,
    input  logic                rst,
    spi_nand_slave_frontend_if.slave spi,
    input  logic                oip,
    output logic                cache_rd_en,
    output logic [CACHE_AW-1:0] cache_rd_addr,
    input  logic [7:0]          cache_rd_data,
    output logic [7:0]          feat_a0,
    output logic [7:0]          feat_b0,
    output logic                wel,
    output logic                reset_req,
    output logic                unsup_cmd
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DUMMY  = 3'd3;
    localparam logic [2:0] S_DOUT   = 3'd4;
    localparam logic [2:0] S_DIN    = 3'd5;
    localparam logic [2:0] S_WAIT   = 3'd6;
    localparam logic [2:0] S_IGNORE = 3'd7;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RESET = 8'hFF;
    localparam logic [7:0] OP_GETF  = 8'h0F;
    localparam logic [7:0] OP_SETF  = 8'h1F;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;

    localparam logic [7:0] FEAT_A0_RST = 8'h38;
    localparam logic [7:0] FEAT_B0_RST = 8'h10;

    logic [1:0] sck_sync, cs_sync, si_sync;
    logic       sck_d, cs_d;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;

    logic [2:0]          state;
    logic [2:0]          bit_cnt;
    logic [6:0]          shift_in;
    logic [7:0]          in_byte;
    logic [7:0]          opcode;
    logic [7:0]          addr_hi;
    logic                hi_pend;
    logic [7:0]          feat_addr;
    logic [CACHE_AW-1:0] col;
    logic                id_sel;
    logic [7:0]          shifter;
    logic [7:0]          prefetch;
    logic                rd_pend;
    logic                so_r;
    logic [7:0]          feat_sel, feat_rd, next_byte;
    logic                is_cache;

    // cs_n synchronizer resets to "selected" so that a reset released in the
    // middle of a frame does not manufacture a cs_n fall; the rest of that
    // frame then stays in IDLE until the host deselects and reselects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= 2'b00;
            cs_sync  <= 2'b00;
            si_sync  <= 2'b00;
            sck_d    <= 1'b0;
            cs_d     <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], spi.sck};
            cs_sync  <= {cs_sync[0], spi.cs_n};
            si_sync  <= {si_sync[0], spi.si};
            sck_d    <= sck_sync[1];
            cs_d     <= cs_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_d;
    assign sck_fall = ~sck_sync[1] & sck_d;
    assign cs_rise  = cs_sync[1] & ~cs_d;
    assign cs_fall  = ~cs_sync[1] & cs_d;
    assign in_byte  = {shift_in, si_sync[1]};
    assign is_cache = (opcode == OP_READ) || (opcode == OP_FREAD);

    // While the address byte itself completes, the feature to return is the
    // byte just shifted in, not the stale feat_addr.
    always_comb begin
        feat_sel = (state == S_ADDR) ? in_byte : feat_addr;
        case (feat_sel)
            8'hA0:   feat_rd = feat_a0;
            8'hB0:   feat_rd = feat_b0;
            8'hC0:   feat_rd = {6'b0, wel, oip};
            default: feat_rd = 8'h00;
        endcase
    end

    always_comb begin
        if (opcode == OP_RDID)      next_byte = id_sel ? ID_DEV : ID_MFR;
        else if (opcode == OP_GETF) next_byte = feat_rd;
        else                        next_byte = prefetch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            bit_cnt       <= 3'd0;
            shift_in      <= 7'd0;
            opcode        <= 8'h00;
            addr_hi       <= 8'h00;
            hi_pend       <= 1'b0;
            feat_addr     <= 8'h00;
            col           <= '0;
            id_sel        <= 1'b0;
            shifter       <= 8'h00;
            prefetch      <= 8'h00;
            rd_pend       <= 1'b0;
            so_r          <= 1'b0;
            cache_rd_en   <= 1'b0;
            cache_rd_addr <= '0;
            feat_a0       <= FEAT_A0_RST;
            feat_b0       <= FEAT_B0_RST;
            wel           <= 1'b0;
            reset_req     <= 1'b0;
            unsup_cmd     <= 1'b0;
        end else begin
            cache_rd_en <= 1'b0;
            reset_req   <= 1'b0;
            unsup_cmd   <= 1'b0;
            rd_pend     <= cache_rd_en;
            if (rd_pend) prefetch <= cache_rd_data;

            if (cs_rise) begin
                // WAIT is only reachable with exactly 8 bits clocked.
                if (state == S_WAIT) begin
                    case (opcode)
                        OP_WREN: wel <= 1'b1;
                        OP_WRDI: wel <= 1'b0;
                        OP_RESET: begin
                            reset_req <= 1'b1;
                            wel       <= 1'b0;
                            feat_a0   <= FEAT_A0_RST;
                            feat_b0   <= FEAT_B0_RST;
                        end
                        default: ;
                    endcase
                end
                state <= S_IDLE;
            end else if (cs_fall) begin
                // cs_n edge wins over any coincident sck edge
                state   <= S_CMD;
                bit_cnt <= 3'd0;
            end else if (state != S_IDLE && state != S_IGNORE) begin
                if (sck_rise) begin
                    shift_in <= in_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    // fetch one byte ahead so the prefetch is ready at the
                    // next byte boundary
                    if (bit_cnt == 3'd0 && is_cache &&
                        (state == S_DUMMY || state == S_DOUT)) begin
                        cache_rd_en   <= 1'b1;
                        cache_rd_addr <= col;
                        col           <= col + CACHE_AW'(1);
                    end
                    if (state == S_WAIT) begin
                        state <= S_IGNORE;
                    end else if (bit_cnt == 3'd7) begin
                        case (state)
                            S_CMD: begin
                                opcode <= in_byte;
                                case (in_byte)
                                    OP_WREN, OP_WRDI, OP_RESET: state <= S_WAIT;
                                    OP_GETF, OP_SETF:           state <= S_ADDR;
                                    OP_RDID: begin
                                        state  <= S_DUMMY;
                                        id_sel <= 1'b0;
                                    end
                                    OP_READ, OP_FREAD: begin
                                        state   <= S_ADDR;
                                        hi_pend <= 1'b1;
                                    end
                                    default: begin
                                        state     <= S_IGNORE;
                                        unsup_cmd <= 1'b1;
                                    end
                                endcase
                            end
                            S_ADDR: begin
                                feat_addr <= in_byte;
                                if (opcode == OP_GETF) begin
                                    shifter <= feat_rd;
                                    state   <= S_DOUT;
                                end else if (opcode == OP_SETF) begin
                                    state <= S_DIN;
                                end else if (hi_pend) begin
                                    addr_hi <= in_byte;
                                    hi_pend <= 1'b0;
                                end else begin
                                    col   <= CACHE_AW'({addr_hi, in_byte});
                                    state <= S_DUMMY;
                                end
                            end
                            S_DUMMY, S_DOUT: begin
                                shifter <= next_byte;
                                id_sel  <= ~id_sel;
                                state   <= S_DOUT;
                            end
                            S_DIN: begin
                                if (feat_addr == 8'hA0)      feat_a0 <= in_byte;
                                else if (feat_addr == 8'hB0) feat_b0 <= in_byte;
                                state <= S_IGNORE;
                            end
                            default: ;
                        endcase
                    end
                end
                if (sck_fall && state == S_DOUT) begin
                    so_r    <= shifter[7];
                    shifter <= {shifter[6:0], 1'b0};
                end
            end
        end
    end

    assign spi.so    = so_r;
    assign spi.so_oe = (state == S_DOUT) & ~cs_sync[1];
endmodule

// File: tb/tb_spi_nand_slave_frontend.sv
// Directed bench for spi_nand_slave_frontend: a mode-0 host drives frames
// through the pin interface and a simple cache model answers reads.
module tb_spi_nand_slave_frontend;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        oip = 1'b0;
    logic        cache_rd_en;
    logic [11:0] cache_rd_addr;
    logic [7:0]  cache_rd_data = 8'h00;
    logic [7:0]  feat_a0, feat_b0;
    logic        wel, reset_req, unsup_cmd;

    logic [7:0]  mem [0:4095];
    logic [7:0]  rx, oe;
    int          n_chk = 0;
    int          n_fail = 0;
    int          rr_cnt = 0;
    int          us_cnt = 0;
    int          base;

    spi_nand_slave_frontend_if spi();

    spi_nand_slave_frontend #(.ID_MFR(8'h2C), .ID_DEV(8'h14), .CACHE_AW(12)) dut (
        .clk(clk), .rst(rst), .spi(spi), .oip(oip),
        .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr),
        .cache_rd_data(cache_rd_data), .feat_a0(feat_a0), .feat_b0(feat_b0),
        .wel(wel), .reset_req(reset_req), .unsup_cmd(unsup_cmd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cache_rd_en) cache_rd_data <= mem[cache_rd_addr];
        if (reset_req) rr_cnt++;
        if (unsup_cmd) us_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // so/so_oe are sampled just before each rise, 50 ns after the prior fall.
    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rxd, output logic [7:0] oed);
        rxd = 8'h00;
        oed = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi.si = tx[7-i];
            #50;
            rxd[7-i] = spi.so;
            oed[7-i] = spi.so_oe;
            spi.sck = 1'b1;
            #50;
            spi.sck = 1'b0;
        end
    endtask

    task automatic cs_lo;
        spi.cs_n = 1'b0;
        #50;
    endtask

    task automatic cs_hi;
        #50;
        spi.cs_n = 1'b1;
        #100;
    endtask

    task automatic cmd_frame(input logic [7:0] op);
        logic [7:0] r, o;
        cs_lo();
        xfer(op, 8, r, o);
        cs_hi();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ctl"}, {26'd0, spi.so, spi.so_oe, wel, cache_rd_en, reset_req, unsup_cmd}, 32'd0);
        chk({tag, ".a0"}, feat_a0, 8'h38);
        chk({tag, ".b0"}, feat_b0, 8'h10);
        chk({tag, ".addr"}, cache_rd_addr, 12'h000);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        spi.sck = 1'b0;
        spi.cs_n = 1'b1;
        spi.si = 1'b0;
        #40;
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        #100;
        chk_reset_vals("rst_rel");

        // Read ID: cmd + dummy with oe low, then 2C,14,2C,14 with oe high
        cs_lo();
        xfer(8'h9F, 8, rx, oe); chk("id.oe_cmd", oe, 8'h00);
        xfer(8'h00, 8, rx, oe); chk("id.oe_dummy", oe, 8'h00);
        xfer(8'h00, 8, rx, oe); chk("id.b0", rx, 8'h2C); chk("id.oe0", oe, 8'hFF);
        xfer(8'h00, 8, rx, oe); chk("id.b1", rx, 8'h14); chk("id.oe1", oe, 8'hFF);
        xfer(8'h00, 8, rx, oe); chk("id.b2", rx, 8'h2C);
        xfer(8'h00, 8, rx, oe); chk("id.b3", rx, 8'h14); chk("id.oe3", oe, 8'hFF);
        #50;
        spi.cs_n = 1'b1;
        #30;
        chk("id.oe_off", spi.so_oe, 1'b0);
        #70;

        // WEL set/clear and status register read
        cmd_frame(8'h06);
        chk("wren.wel", wel, 1'b1);
        cs_lo();
        xfer(8'h0F, 8, rx, oe); xfer(8'hC0, 8, rx, oe);
        xfer(8'h00, 8, rx, oe); chk("getf.c0_wel", rx, 8'h02);
        xfer(8'h00, 8, rx, oe); chk("getf.c0_rep", rx, 8'h02);
        cs_hi();
        cmd_frame(8'h04);
        chk("wrdi.wel", wel, 1'b0);
        oip = 1'b1;
        cs_lo();
        xfer(8'h0F, 8, rx, oe); xfer(8'hC0, 8, rx, oe);
        xfer(8'h00, 8, rx, oe); chk("getf.c0_oip", rx, 8'h01);
        cs_hi();
        oip = 1'b0;

        // Feature writes: full commit, then truncated write
        cs_lo();
        xfer(8'h1F, 8, rx, oe); xfer(8'hA0, 8, rx, oe); xfer(8'h00, 8, rx, oe);
        cs_hi();
        chk("setf.a0", feat_a0, 8'h00);
        cs_lo();
        xfer(8'h1F, 8, rx, oe); xfer(8'hB0, 8, rx, oe); xfer(8'h00, 5, rx, oe);
        cs_hi();
        chk("setf.b0_short", feat_b0, 8'h10);
        cs_lo();
        xfer(8'h0F, 8, rx, oe); xfer(8'hA0, 8, rx, oe);
        xfer(8'h00, 8, rx, oe); chk("getf.a0", rx, 8'h00);
        cs_hi();

        // Cache read across the column wrap
        cs_lo();
        xfer(8'h03, 8, rx, oe); xfer(8'h0F, 8, rx, oe); xfer(8'hFE, 8, rx, oe);
        xfer(8'h00, 8, rx, oe); chk("rd.oe_dummy", oe, 8'h00);
        xfer(8'h00, 8, rx, oe); chk("rd.b0", rx, 8'hFE);
        xfer(8'h00, 8, rx, oe); chk("rd.b1", rx, 8'hFF);
        xfer(8'h00, 8, rx, oe); chk("rd.b2", rx, 8'h00);
        xfer(8'h00, 8, rx, oe); chk("rd.b3", rx, 8'h01);
        cs_hi();

        // 06 with a 9th clock is cancelled
        cs_lo();
        xfer(8'h06, 8, rx, oe); xfer(8'h00, 1, rx, oe);
        cs_hi();
        chk("wren9.wel", wel, 1'b0);

        // Undefined opcode
        base = us_cnt;
        cs_lo();
        xfer(8'h5A, 8, rx, oe); chk("unsup.oe_cmd", oe, 8'h00);
        xfer(8'h00, 8, rx, oe); chk("unsup.oe_after", oe, 8'h00);
        cs_hi();
        chk("unsup.pulses", us_cnt - base, 1);

        // Reset command restores features and clears WEL
        cmd_frame(8'h06);
        base = rr_cnt;
        cmd_frame(8'hFF);
        chk("rstcmd.pulses", rr_cnt - base, 1);
        chk("rstcmd.wel", wel, 1'b0);
        chk("rstcmd.a0", feat_a0, 8'h38);

        // Hardware reset in the middle of a 03 address
        cs_lo();
        xfer(8'h1F, 8, rx, oe); xfer(8'hB0, 8, rx, oe); xfer(8'h55, 8, rx, oe);
        cs_hi();
        chk("setf.b0", feat_b0, 8'h55);
        base = us_cnt;
        cs_lo();
        xfer(8'h03, 8, rx, oe); xfer(8'h0F, 4, rx, oe);
        rst = 1'b1;
        #20;
        chk_reset_vals("midrst");
        rst = 1'b0;
        #20;
        xfer(8'h0F, 4, rx, oe);
        xfer(8'hFE, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        xfer(8'h00, 8, rx, oe); chk("midrst.oe", oe, 8'h00);
        cs_hi();
        chk("midrst.unsup", us_cnt - base, 0);
        chk_reset_vals("postrst");

        cs_lo();
        xfer(8'h9F, 8, rx, oe); xfer(8'h00, 8, rx, oe);
        xfer(8'h00, 8, rx, oe); chk("id2.b0", rx, 8'h2C);
        xfer(8'h00, 8, rx, oe); chk("id2.b1", rx, 8'h14);
        cs_hi();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
